inst_fetch_unit: RTL and testbench

//  Fetch-side initiator for the 1-cycle registered instruction memory. Drives the

---
 rtl/inst_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator for a 1-cycle registered instruction memory.
// Issues sequential fetches, buffers one word under decode backpressure, redirects on branch, and halts on a memory fault.
module inst_fetch_unit #(
  parameter int unsigned                   INSTR_ADDR_WIDTH     = 16,
  parameter int unsigned                   INSTR_DATA_BIT_WIDTH = 16,
  parameter logic [INSTR_ADDR_WIDTH-1:0]   RESET_PC             = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_en,
  output logic [INSTR_ADDR_WIDTH-1:0]     mem_addr,
  input  logic [INSTR_DATA_BIT_WIDTH-1:0] mem_data,
  input  logic                            mem_exc,
  input  logic                            br_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0]     br_target,
  output logic                            id_valid,
  input  logic                            id_ready,
  output logic [INSTR_DATA_BIT_WIDTH-1:0] id_instr,
  output logic [INSTR_ADDR_WIDTH-1:0]     id_pc,
  output logic                            fault,
  output logic [INSTR_ADDR_WIDTH-1:0]     fault_pc
);

  localparam int unsigned AW = INSTR_ADDR_WIDTH;
  localparam int unsigned DW = INSTR_DATA_BIT_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            req_q, req_d;
  logic [AW-1:0]   req_pc_q, req_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [DW-1:0]   skid_instr_q, skid_instr_d;
  logic [AW-1:0]   skid_pc_q, skid_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [DW-1:0]   id_instr_q, id_instr_d;
  logic [AW-1:0]   id_pc_q, id_pc_d;
  logic            fault_q, fault_d;
  logic [AW-1:0]   fault_pc_q, fault_pc_d;

  logic            out_free_s;
  logic            rsp_ok_s;
  logic            fault_take_s;
  logic            branch_s;
  logic            issue_en_s;

  // Next-state logic: issue control, response routing, redirect and fault capture
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    req_d        = 1'b0;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;

    out_free_s   = !id_valid_q || id_ready;
    rsp_ok_s     = req_q && !mem_exc;
    branch_s     = br_valid && (state_q != ST_FAULT);
    fault_take_s = req_q && mem_exc && !br_valid && (state_q != ST_FAULT);
    // An issue while the output is stalled with a word in flight could overflow the skid slot
    issue_en_s   = (state_q == ST_RUN) && !skid_valid_q &&
                   !(req_q && id_valid_q && !id_ready) && !fault_take_s;

    case (state_q)
      ST_IDLE: begin
        if (fetch_en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!fetch_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase

    if (fault_take_s) begin
      state_d    = ST_FAULT;
      fault_d    = 1'b1;
      fault_pc_d = req_pc_q;
    end else begin
      fault_d    = fault_q;
    end

    if (branch_s) begin
      mem_addr_d   = br_target;
      req_d        = 1'b0;
      skid_valid_d = 1'b0;
      id_valid_d   = 1'b0;
    end else begin
      if (issue_en_s) begin
        req_d      = 1'b1;
        req_pc_d   = mem_addr_q;
        mem_addr_d = mem_addr_q + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        req_d      = 1'b0;
      end

      if (out_free_s) begin
        if (skid_valid_q) begin
          id_valid_d   = 1'b1;
          id_instr_d   = skid_instr_q;
          id_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (rsp_ok_s) begin
          id_valid_d   = 1'b1;
          id_instr_d   = mem_data;
          id_pc_d      = req_pc_q;
        end else begin
          id_valid_d   = 1'b0;
        end
      end else begin
        if (rsp_ok_s) begin
          skid_valid_d = 1'b1;
          skid_instr_d = mem_data;
          skid_pc_d    = req_pc_q;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end
    end
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= RESET_PC;
      req_q        <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      req_q        <= req_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign fault    = fault_q;
  assign fault_pc = fault_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: registered memory model, delivery scoreboard,
// hand-written corner sequences and a table of redirect vectors.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_exc;
  logic        br_valid;
  logic [15:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        fault;
  logic [15:0] fault_pc;

  logic [15:0] exc_lo;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_item_t;

  typedef struct {
    logic [15:0] target;
    logic [15:0] exp_pc;
    logic [15:0] exp_instr;
    logic [15:0] exp_addr;
  } br_vec_t;

  sb_item_t sb_q[$];
  int n_tests;
  int n_fail;

  inst_fetch_unit #(
    .INSTR_ADDR_WIDTH(16),
    .INSTR_DATA_BIT_WIDTH(16),
    .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_exc(mem_exc),
    .br_valid(br_valid),
    .br_target(br_target),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .fault(fault),
    .fault_pc(fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word at address a is 0x1000+a; out of range is [exc_lo, 0xFF00)
  always @(posedge clk) begin
    mem_data <= 16'h1000 + mem_addr;
    mem_exc  <= (mem_addr >= exc_lo) && (mem_addr < 16'hFF00);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] pc);
    sb_item_t e;
    e.pc    = pc;
    e.instr = 16'h1000 + pc;
    sb_q.push_back(e);
  endtask

  // One clock: score the handshake happening at the coming posedge, then move to the next negedge
  task automatic cycle();
    sb_item_t e;
    if (id_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: actual pc %0h instr %0h required no delivery", id_pc, id_instr);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", {16'h0, id_pc}, {16'h0, e.pc});
        chk("sb_instr", {16'h0, id_instr}, {16'h0, e.instr});
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_pc(input logic [15:0] pc, input int lim, input string nm);
    int k;
    k = 0;
    while (!(id_valid && id_pc == pc) && k < lim) begin
      cycle();
      k++;
    end
    chk(nm, {31'h0, (id_valid && id_pc == pc)}, 32'h1);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_valid"}, {31'h0, id_valid}, 32'h0);
    chk({nm, "_instr"}, {16'h0, id_instr}, 32'h0);
    chk({nm, "_pc"}, {16'h0, id_pc}, 32'h0);
    chk({nm, "_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({nm, "_fault"}, {31'h0, fault}, 32'h0);
    chk({nm, "_fault_pc"}, {16'h0, fault_pc}, 32'h0);
  endtask

  initial begin
    br_vec_t vec[5];
    int k;
    n_tests = 0;
    n_fail  = 0;
    vec[0] = '{16'h0005, 16'h0005, 16'h1005, 16'h0007};
    vec[1] = '{16'h003D, 16'h003D, 16'h103D, 16'h003F};
    vec[2] = '{16'hFFFF, 16'hFFFF, 16'h0FFF, 16'h0001};
    vec[3] = '{16'hFFFE, 16'hFFFE, 16'h0FFE, 16'h0000};
    vec[4] = '{16'h0000, 16'h0000, 16'h1000, 16'h0002};

    rst = 1'b0; fetch_en = 1'b0; br_valid = 1'b0; br_target = 16'h0;
    id_ready = 1'b1; exc_lo = 16'h0040;
    #1;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("idle_addr", {16'h0, mem_addr}, 32'h0);
    chk("idle_valid", {31'h0, id_valid}, 32'h0);

    // Straight-line fetch and latency
    for (int i = 0; i < 7; i++) push_exp(16'(i));
    fetch_en = 1'b1;
    cycle();
    chk("t1_addr0", {16'h0, mem_addr}, 32'h0);
    chk("t1_v0", {31'h0, id_valid}, 32'h0);
    cycle();
    chk("t1_addr1", {16'h0, mem_addr}, 32'h1);
    chk("t1_v1", {31'h0, id_valid}, 32'h0);
    cycle();
    chk("t1_v2", {31'h0, id_valid}, 32'h1);
    chk("t1_pc2", {16'h0, id_pc}, 32'h0);
    chk("t1_instr2", {16'h0, id_instr}, 32'h1000);
    chk("t1_addr2", {16'h0, mem_addr}, 32'h2);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      chk("t1_stream_valid", {31'h0, id_valid}, 32'h1);
      chk("t1_stream_pc", {16'h0, id_pc}, 32'(i));
      chk("t1_stream_addr", {16'h0, mem_addr}, 32'(i + 2));
    end

    // Backpressure: three stalled cycles, output and address frozen
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_valid", {31'h0, id_valid}, 32'h1);
      chk("t2_hold_pc", {16'h0, id_pc}, 32'h3);
      chk("t2_hold_instr", {16'h0, id_instr}, 32'h1003);
      chk("t2_hold_addr", {16'h0, mem_addr}, 32'h5);
    end
    id_ready = 1'b1;
    wait_pc(16'h0007, 20, "t2_reach7");

    // Branch with words 7 and 8 in flight and decode stalled: both dropped
    for (int i = 16'h20; i < 16'h40; i++) push_exp(16'(i));
    id_ready  = 1'b0;
    br_valid  = 1'b1;
    br_target = 16'h0020;
    cycle();
    br_valid = 1'b0;
    id_ready = 1'b1;
    chk("t3_v0", {31'h0, id_valid}, 32'h0);
    chk("t3_addr0", {16'h0, mem_addr}, 32'h20);
    cycle();
    chk("t3_v1", {31'h0, id_valid}, 32'h0);
    chk("t3_addr1", {16'h0, mem_addr}, 32'h21);
    cycle();
    chk("t3_v2", {31'h0, id_valid}, 32'h1);
    chk("t3_pc2", {16'h0, id_pc}, 32'h20);
    chk("t3_instr2", {16'h0, id_instr}, 32'h1020);

    // Run into the out-of-range address 0x40
    k = 0;
    while (!fault && k < 60) begin
      cycle();
      k++;
    end
    chk("t4_fault", {31'h0, fault}, 32'h1);
    chk("t4_fault_pc", {16'h0, fault_pc}, 32'h40);
    chk("t4_no_valid", {31'h0, id_valid}, 32'h0);
    chk("t4_sb_drained", 32'(sb_q.size()), 32'h0);
    chk("t4_addr", {16'h0, mem_addr}, 32'h41);
    br_valid  = 1'b1;
    br_target = 16'h0005;
    cycle();
    br_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_br_ignored_addr", {16'h0, mem_addr}, 32'h41);
    chk("t4_br_ignored_valid", {31'h0, id_valid}, 32'h0);
    chk("t4_sticky", {31'h0, fault}, 32'h1);
    chk("t4_sticky_pc", {16'h0, fault_pc}, 32'h40);

    // Asynchronous reset out of FAULT, then again with the skid buffer full
    #2 rst = 1'b0;
    #1 chk_cleared("t5_rst_fault");
    @(negedge clk);
    rst = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0001);
    wait_pc(16'h0001, 10, "t5_reach1");
    id_ready = 1'b0;
    cycle();
    cycle();
    chk("t5_stalled_pc", {16'h0, id_pc}, 32'h1);
    #2 rst = 1'b0;
    #1 chk_cleared("t5_rst_skid");
    sb_q.delete();
    @(negedge clk);
    rst      = 1'b1;
    id_ready = 1'b1;
    exc_lo   = 16'h0004;
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    k = 0;
    while (!id_valid && k < 10) begin
      cycle();
      k++;
    end
    chk("t5_first_pc", {16'h0, id_pc}, 32'h0);

    // Branch in the same cycle as an exception response: redirect wins, no fault
    wait_pc(16'h0003, 10, "t6_reach3");
    chk("t6_exc_present", {31'h0, mem_exc}, 32'h1);
    for (int i = 16'h30; i < 16'h33; i++) push_exp(16'(i));
    br_valid  = 1'b1;
    br_target = 16'h0030;
    exc_lo    = 16'h0040;
    cycle();
    br_valid = 1'b0;
    chk("t6_no_fault", {31'h0, fault}, 32'h0);
    cycle();
    cycle();
    chk("t6_valid", {31'h0, id_valid}, 32'h1);
    chk("t6_pc", {16'h0, id_pc}, 32'h30);
    chk("t6_no_fault_late", {31'h0, fault}, 32'h0);
    k = 0;
    while (sb_q.size() > 0 && k < 10) begin
      cycle();
      k++;
    end
    id_ready = 1'b0;

    // Redirect vectors under stalled decode, including address wrap
    for (int i = 0; i < 5; i++) begin
      br_valid  = 1'b1;
      br_target = vec[i].target;
      cycle();
      br_valid = 1'b0;
      for (int j = 0; j < 4; j++) cycle();
      chk("vec_valid", {31'h0, id_valid}, 32'h1);
      chk("vec_pc", {16'h0, id_pc}, {16'h0, vec[i].exp_pc});
      chk("vec_instr", {16'h0, id_instr}, {16'h0, vec[i].exp_instr});
      chk("vec_addr", {16'h0, mem_addr}, {16'h0, vec[i].exp_addr});
    end

    chk("final_sb_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
